// File: rtl/gpio_access_controller.sv
// gpio_access_controller
//   Arbitrates two requesters onto a GPIO peripheral register bus and
//   sequences each access as SETUP -> STROBE -> (CAPTURE) -> DONE.
//
// Ports
//   clk, reset            : clock, async active-high reset
//   req0/1, op0/1, wdata0/1 : requester side (op 00 rd IN, 01 wr OUT, 10 wr DIR, 11 illegal)
//   ack0/1, err, rdata    : completion pulse, illegal-op flag (valid with ack), last read data
//   busy                  : controller not idle
//   Read_In, Load_Out, Load_DIR : peripheral strobes
//   addressbus            : peripheral register address
//   db_out, db_oe, db_in  : databus drive value / enable / sampled value (tristate is external)
module gpio_access_controller #(
    parameter logic [7:0]  ADDR_IN      = 8'h04,
    parameter logic [7:0]  ADDR_OUT     = 8'h05,
    parameter logic [7:0]  ADDR_DIR     = 8'h06,
    parameter int unsigned SETUP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        Read_In,
    output logic        Load_Out,
    output logic        Load_DIR,
    output logic [7:0]  addressbus,
    output logic [15:0] db_out,
    output logic        db_oe,
    input  logic [15:0] db_in
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, DONE} state_t;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WO  = 2'b01;
    localparam logic [1:0] OP_WD  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [3:0] SETUP_INIT = 4'(SETUP_CYCLES);

    // Transaction latched at grant; requester inputs are ignored afterwards.
    typedef struct packed {
        logic        id;
        logic [1:0]  op;
        logic [15:0] wdata;
    } txn_t;

    state_t      state_q, state_d;
    txn_t        txn_q, txn_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;     // last-served requester
    logic [15:0] rdata_q, rdata_d;

    logic        grant_id;
    logic [1:0]  grant_op;
    logic        is_write;
    logic [7:0]  op_addr;

    // On a tie the requester not served last wins; otherwise the lone requester.
    assign grant_id = (req0 && req1) ? ~last_q : req1;
    assign grant_op = grant_id ? op1 : op0;

    assign is_write = (txn_q.op == OP_WO) || (txn_q.op == OP_WD);

    always_comb begin
        op_addr = 8'h00;
        case (txn_q.op)
            OP_RD:   op_addr = ADDR_IN;
            OP_WO:   op_addr = ADDR_OUT;
            OP_WD:   op_addr = ADDR_DIR;
            default: op_addr = 8'h00;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    txn_d.id    = grant_id;
                    txn_d.op    = grant_op;
                    txn_d.wdata = grant_id ? wdata1 : wdata0;
                    if (grant_op == OP_ILL) begin
                        state_d = DONE;
                    end else begin
                        state_d = SETUP;
                        cnt_d   = SETUP_INIT;
                    end
                end
            end
            SETUP: begin
                // Counter holds remaining setup cycles including this one.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                state_d = (txn_q.op == OP_RD) ? CAPTURE : DONE;
            end
            CAPTURE: begin
                rdata_d = db_in;
                state_d = DONE;
            end
            DONE: begin
                last_d  = txn_q.id;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the registered state so reset clears them at once.
    always_comb begin
        ack0       = 1'b0;
        ack1       = 1'b0;
        err        = 1'b0;
        Read_In    = 1'b0;
        Load_Out   = 1'b0;
        Load_DIR   = 1'b0;
        addressbus = 8'h00;
        db_out     = 16'h0000;
        db_oe      = 1'b0;
        case (state_q)
            SETUP: begin
                addressbus = op_addr;
                if (is_write) begin
                    db_out = txn_q.wdata;
                    db_oe  = 1'b1;
                end
            end
            STROBE: begin
                addressbus = op_addr;
                if (is_write) begin
                    db_out = txn_q.wdata;
                    db_oe  = 1'b1;
                end
                Load_Out = (txn_q.op == OP_WO);
                Load_DIR = (txn_q.op == OP_WD);
                Read_In  = (txn_q.op == OP_RD);
            end
            CAPTURE: begin
                addressbus = op_addr;
                Read_In    = 1'b1;
            end
            DONE: begin
                ack0 = ~txn_q.id;
                ack1 = txn_q.id;
                err  = (txn_q.op == OP_ILL);
            end
            default: ;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign rdata = rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            txn_q   <= '0;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;   // requester 0 wins the first tie
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_gpio_access_controller.sv
module tb_gpio_access_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [15:0] wdata0, wdata1, db_in;

    logic        ack0, ack1, err, busy, Read_In, Load_Out, Load_DIR, db_oe;
    logic [15:0] rdata, db_out;
    logic [7:0]  addressbus;

    logic        b_ack0, b_ack1, b_err, b_busy, b_Read_In, b_Load_Out, b_Load_DIR, b_db_oe;
    logic [15:0] b_rdata, b_db_out;
    logic [7:0]  b_addressbus;

    gpio_access_controller dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy),
        .Read_In(Read_In), .Load_Out(Load_Out), .Load_DIR(Load_DIR),
        .addressbus(addressbus), .db_out(db_out), .db_oe(db_oe), .db_in(db_in)
    );

    gpio_access_controller #(.SETUP_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(b_ack0), .ack1(b_ack1), .err(b_err), .rdata(b_rdata), .busy(b_busy),
        .Read_In(b_Read_In), .Load_Out(b_Load_Out), .Load_DIR(b_Load_DIR),
        .addressbus(b_addressbus), .db_out(b_db_out), .db_oe(b_db_oe), .db_in(db_in)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle invariants on the default instance.
    task automatic chk_inv();
        chk("onehot_strobe", 32'($countones({Read_In, Load_Out, Load_DIR}) <= 1), 1);
        chk("oe_with_read", 32'(db_oe && Read_In), 0);
        if (!busy)
            chk("idle_bus_quiet", {addressbus, db_out, db_oe, Read_In, Load_Out, Load_DIR}, 0);
    endtask

    typedef struct {
        logic        r;
        logic [1:0]  op;
        logic [15:0] wd;
        logic [15:0] din;
        int          lat;
        logic        err;
        logic [2:0]  strb;   // {Read_In, Load_Out, Load_DIR}
        logic [7:0]  addr;
        logic [15:0] dout;
        logic [15:0] rdata;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int ack_at = -1;
        int acks = 0;
        int scnt = 0;
        logic ack_id = 1'b0;
        logic ack_err = 1'b0;
        logic [2:0] smask = 3'b000;
        logic [7:0] s_addr = 8'h00;
        logic [15:0] s_dout = 16'h0000;
        int exp_scnt;
        exp_scnt = (v.op == 2'b11) ? 0 : (v.op == 2'b00) ? 2 : 1;
        @(negedge clk);
        if (v.r == 1'b0) begin req0 = 1'b1; op0 = v.op; wdata0 = v.wd; end
        else             begin req1 = 1'b1; op1 = v.op; wdata1 = v.wd; end
        db_in = v.din;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk_inv();
            if (v.op == 2'b11) chk("illegal_addr_quiet", {addressbus, db_oe}, 0);
            if (v.op == 2'b00) chk("read_no_oe", 32'(db_oe), 0);
            if (Read_In || Load_Out || Load_DIR) begin
                if (scnt == 0) begin s_addr = addressbus; s_dout = db_out; end
                scnt++;
                smask = smask | {Read_In, Load_Out, Load_DIR};
            end
            if (ack0 || ack1) begin
                acks++;
                if (ack_at < 0) begin ack_at = k; ack_id = ack1; ack_err = err; end
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        chk("ack_latency", ack_at, v.lat);
        chk("ack_id", 32'(ack_id), 32'(v.r));
        chk("ack_err", 32'(ack_err), 32'(v.err));
        chk("ack_count", acks, 1);
        chk("strobe_kind", 32'(smask), 32'(v.strb));
        chk("strobe_cycles", scnt, exp_scnt);
        chk("strobe_addr", 32'(s_addr), 32'(v.addr));
        chk("strobe_dout", 32'(s_dout), 32'(v.dout));
        chk("rdata", 32'(rdata), 32'(v.rdata));
        chk("busy_after", 32'(busy), 0);
    endtask

    // Two simultaneous requests held until their own ack.
    task automatic run_tie(input logic [1:0] o0, input logic [15:0] w0,
                           input logic [1:0] o1, input logic [15:0] w1,
                           output int a0, output int a1, output int n,
                           output logic [15:0] d0, output logic [15:0] d1);
        a0 = -1; a1 = -1; n = 0; d0 = 16'h0; d1 = 16'h0;
        @(negedge clk);
        req0 = 1'b1; op0 = o0; wdata0 = w0;
        req1 = 1'b1; op1 = o1; wdata1 = w1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk_inv();
            if (Load_Out || Load_DIR) begin
                if (n == 0) d0 = db_out; else d1 = db_out;
                n++;
            end
            if (ack0 && a0 < 0) begin a0 = k; req0 = 1'b0; end
            if (ack1 && a1 < 0) begin a1 = k; req1 = 1'b0; end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t vecs[7];
    int   a0, a1, n, ack_at, rd_at;
    logic [15:0] d0, d1;
    logic seen_err;

    initial begin
        vecs[0] = '{1'b0, 2'b10, 16'hFFFF, 16'h0000, 3, 1'b0, 3'b001, 8'h06, 16'hFFFF, 16'h0000};
        vecs[1] = '{1'b1, 2'b00, 16'h0000, 16'h0003, 4, 1'b0, 3'b100, 8'h04, 16'h0000, 16'h0003};
        vecs[2] = '{1'b0, 2'b11, 16'hBEEF, 16'h0000, 1, 1'b1, 3'b000, 8'h00, 16'h0000, 16'h0003};
        vecs[3] = '{1'b1, 2'b01, 16'h1234, 16'h0000, 3, 1'b0, 3'b010, 8'h05, 16'h1234, 16'h0003};
        vecs[4] = '{1'b0, 2'b00, 16'h0000, 16'hA5A5, 4, 1'b0, 3'b100, 8'h04, 16'h0000, 16'hA5A5};
        vecs[5] = '{1'b1, 2'b11, 16'h0000, 16'h0000, 1, 1'b1, 3'b000, 8'h00, 16'h0000, 16'hA5A5};
        vecs[6] = '{1'b1, 2'b10, 16'h0000, 16'hFFFF, 3, 1'b0, 3'b001, 8'h06, 16'h0000, 16'hA5A5};

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; op0 = 2'b00; op1 = 2'b00;
        wdata0 = 16'h0; wdata1 = 16'h0; db_in = 16'h0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {ack0, ack1, err, busy, Read_In, Load_Out, Load_DIR, db_oe, addressbus, db_out, rdata}, 0);
        chk("reset_outputs_s3", {b_ack0, b_ack1, b_err, b_busy, b_rdata, b_addressbus, b_db_oe}, 0);
        reset = 1'b0;

        // Table of single transactions, back to back without reset.
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // First tie after reset: requester 0 first, then requester 1.
        pulse_reset();
        run_tie(2'b01, 16'h0008, 2'b01, 16'h0001, a0, a1, n, d0, d1);
        chk("tie_ack0_at", a0, 3);
        chk("tie_ack1_at", a1, 7);
        chk("tie_load_count", n, 2);
        chk("tie_dout_first", 32'(d0), 32'h0008);
        chk("tie_dout_second", 32'(d1), 32'h0001);

        // After serving requester 0, a tie goes to requester 1.
        pulse_reset();
        run_vec('{1'b0, 2'b01, 16'h00AA, 16'h0000, 3, 1'b0, 3'b010, 8'h05, 16'h00AA, 16'h0000});
        run_tie(2'b01, 16'h0BB0, 2'b10, 16'h0CC0, a0, a1, n, d0, d1);
        chk("rr_ack1_at", a1, 3);
        chk("rr_ack0_at", a0, 7);
        chk("rr_dout_first", 32'(d0), 32'h0CC0);
        chk("rr_dout_second", 32'(d1), 32'h0BB0);

        // Inputs latched at grant; dropping req does not abort.
        @(negedge clk);
        req0 = 1'b1; op0 = 2'b01; wdata0 = 16'h1111;
        @(negedge clk);
        req0 = 1'b0; op0 = 2'b11; wdata0 = 16'h2222;
        ack_at = -1; d0 = 16'h0; seen_err = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            chk_inv();
            if (Load_Out) d0 = db_out;
            if (ack0 && ack_at < 0) begin ack_at = k; seen_err = err; end
        end
        chk("latch_ack_at", ack_at, 3);
        chk("latch_err", 32'(seen_err), 0);
        chk("latch_dout", 32'(d0), 32'h1111);

        // Reset during STROBE of a DIR write.
        @(negedge clk);
        req0 = 1'b1; op0 = 2'b10; wdata0 = 16'hFFFF;
        @(negedge clk);
        chk("setup_addr", 32'(addressbus), 32'h06);
        chk("setup_oe", 32'(db_oe), 1);
        chk("setup_no_strobe", 32'(Load_DIR), 0);
        @(negedge clk);
        chk("strobe_dir", 32'(Load_DIR), 1);
        chk("strobe_addr_dir", 32'(addressbus), 32'h06);
        chk("strobe_dout_dir", 32'(db_out), 32'hFFFF);
        #1 reset = 1'b1;
        req0 = 1'b0;
        #1;
        chk("midreset_quiet", {Load_DIR, Load_Out, Read_In, db_oe, busy, ack0, ack1, addressbus, db_out}, 0);
        @(negedge clk);
        reset = 1'b0;
        a0 = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack0 || ack1) a0++;
        end
        chk("no_ack_after_reset", a0, 0);
        run_vec('{1'b1, 2'b00, 16'h0000, 16'h5A5A, 4, 1'b0, 3'b100, 8'h04, 16'h0000, 16'h5A5A});

        // SETUP_CYCLES=3 read on the second instance.
        pulse_reset();
        @(negedge clk);
        req1 = 1'b1; op1 = 2'b00; db_in = 16'h00C3;
        ack_at = -1; rd_at = -1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("s3_oe_with_read", 32'(b_db_oe && b_Read_In), 0);
            if (b_Read_In && rd_at < 0) rd_at = k;
            if (b_ack1 && ack_at < 0) begin ack_at = k; req1 = 1'b0; end
        end
        chk("s3_read_in_at", rd_at, 4);
        chk("s3_ack_at", ack_at, 6);
        chk("s3_rdata", 32'(b_rdata), 32'h00C3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gpio_access_controller.md
GPIO_ACCESS_CONTROLLER -- requirements
Module: gpio_access_controller

Interface
REQ-001 The block SHALL have parameter ADDR_IN, default 8'h04, which is the GPIO input-register address.
REQ-002 The block SHALL have parameter ADDR_OUT, default 8'h05, which is the GPIO output-register address.
REQ-003 The block SHALL have parameter ADDR_DIR, default 8'h06, which is the GPIO direction-register address.
REQ-004 The block SHALL have parameter SETUP_CYCLES, default 1, range 1-15, which sets the address/data setup time before the strobe.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have ports req0 and req1, input, 1 bit each: requester transaction request.
REQ-008 The block SHALL have ports op0 and op1, input, 2 bits each: 00 = read IN, 01 = write OUT, 10 = write DIR, 11 = illegal.
REQ-009 The block SHALL have ports wdata0 and wdata1, input, 16 bits each: write data.
REQ-010 The block SHALL have ports ack0 and ack1, output, 1 bit each: one-cycle completion pulse.
REQ-011 The block SHALL have port err, output, 1 bit: valid with an ack; set for an illegal op.
REQ-012 The block SHALL have port rdata, output, 16 bits: last read result.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 The block SHALL have ports Read_In, Load_Out and Load_DIR, output, 1 bit each: GPIO peripheral strobes.
REQ-015 The block SHALL have port addressbus, output, 8 bits: GPIO register address.
REQ-016 The block SHALL have ports db_out (output, 16 bits), db_oe (output, 1 bit) and db_in (input, 16 bits): databus drive value, drive enable, and sampled value; tristating is done outside this block.

Function
REQ-017 The FSM states SHALL be IDLE, SETUP, STROBE, CAPTURE and DONE.
REQ-018 Arbitration in IDLE SHALL be as follows: a single request is granted; on simultaneous req0 and req1, the requester not served last is granted (round-robin, last-served pointer).
REQ-019 On grant, the block SHALL latch the requester id, op and wdata; later changes on that requester's inputs are ignored until ack.
REQ-020 For an illegal op, IDLE SHALL go to DONE with err=1 and no strobe, address or db_oe activity.
REQ-021 For a legal op, IDLE SHALL go to SETUP, and the counter SHALL load SETUP_CYCLES.
REQ-022 SETUP SHALL drive addressbus with the op address; writes SHALL drive db_out=wdata with db_oe=1; the state SHALL stay until the counter expires (SETUP_CYCLES cycles), then go to STROBE.
REQ-023 STROBE SHALL last exactly 1 cycle and assert Load_OUT or Load_DIR (write) or Read_In (read); the address and write data SHALL be held.
REQ-024 After STROBE, writes SHALL go to DONE and reads SHALL go to CAPTURE.
REQ-025 CAPTURE SHALL last 1 cycle with Read_In=1 and db_oe=0; rdata SHALL load db_in on the clock edge leaving CAPTURE.
REQ-026 DONE SHALL last 1 cycle and pulse ack of the granted requester, with err valid; it SHALL update the last-served pointer and go to IDLE.
REQ-027 Latency with SETUP_CYCLES=1, measured from the cycle req is sampled in IDLE, SETUP_CYCLES=1 being the minimum latency: write ack SHALL be at +3 and read ack at +4; each extra setup cycle SHALL add 1.
REQ-028 At most one strobe SHALL be high in any cycle; db_oe SHALL never be 1 while Read_In=1.
REQ-029 Outside SETUP, STROBE and CAPTURE, addressbus SHALL be 8'h00, db_out 16'h0000, db_oe 0 and all strobes 0.
REQ-030 A requester SHALL hold req until its ack; a req still high in the cycle after ack SHALL be treated as a new request.
REQ-031 A req deasserted mid-transaction SHALL NOT abort it; the transaction SHALL complete and ack SHALL still pulse.
REQ-032 rdata SHALL be unchanged by writes and illegal ops.

Reset
REQ-033 Reset SHALL act asynchronously, at any time including mid-transaction, forcing state IDLE.
REQ-034 Reset SHALL force all strobes 0, addressbus 8'h00, db_out 16'h0000, db_oe 0, ack0/ack1 0, err 0, busy 0, rdata 16'h0000, counter 0, and the last-served pointer to requester 1 so that requester 0 wins the first tie.
REQ-035 An interrupted transaction SHALL NOT be acked after reset release.

Verification
REQ-036 req0, op0=10, wdata0=16'hFFFF, SETUP_CYCLES=1 -> addressbus=8'h06 and db_oe=1 at +1..+2; Load_DIR=1 at +2 only; ack0 at +3 with err=0.
REQ-037 req1, op1=00, db_in=16'h0003 -> addressbus=8'h04 and Read_In=1 at +2..+3; db_oe=0 throughout; ack1 at +4; rdata=16'h0003.
REQ-038 req0 and req1 both write OUT (16'h0008 and 16'h0001), held until acked, first arbitration after reset -> requester 0 served first; requester 1 next; ack0 then ack1; Load_Out pulses twice with db_out 16'h0008 then 16'h0001.
REQ-039 op0=11 -> ack0 and err=1 at +1; no strobe; addressbus stays 8'h00.
REQ-040 reset asserted during STROBE of a write -> strobes and db_oe drop immediately; no ack; busy=0; the next request proceeds normally.
REQ-041 SETUP_CYCLES=3 read -> Read_In asserted at +4, ack at +6.
